// File: rtl/rover_io_pkg.sv
// Shared rover I/O definitions: button FSM state encoding and default timing for the 50 MHz clock.
package rover_io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  localparam int unsigned BTN_HOLD_CYCLES   = 50_000_000;
  localparam int unsigned BTN_REPEAT_CYCLES = 10_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear and count enable; flags when the count equals a runtime limit.
module cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done_c
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done_c = (count == limit);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/hold/repeat pulses plus pressed and hold levels.
module button_event
  import rover_io_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned HOLD_CYCLES   = BTN_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clean_in,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse,
  output logic pressed,
  output logic hold_active
);

  localparam logic             ACT_LEVEL = ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic             REPEAT_ON = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LIM   = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  btn_state_t       state, state_n;
  logic             prev_active;
  logic             active;
  logic             tmr_clear, tmr_en, tmr_done;
  logic [CNT_W-1:0] tmr_limit;
  logic [CNT_W-1:0] tmr_count;
  logic             press_n, release_n, hold_n, repeat_n, pressed_n, hold_active_n;

  assign active    = (clean_in == ACT_LEVEL);
  assign tmr_limit = (state == HELD) ? REP_LIM : HOLD_LIM;

  // One timer serves both phases; the limit switches from hold to repeat period in HELD.
  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .limit  (tmr_limit),
    .count  (tmr_count),
    .done_c (tmr_done)
  );

  // Next-state and next-output decode; release is checked before any threshold so it wins.
  always_comb begin
    state_n       = state;
    tmr_clear     = 1'b0;
    tmr_en        = 1'b0;
    press_n       = 1'b0;
    release_n     = 1'b0;
    hold_n        = 1'b0;
    repeat_n      = 1'b0;
    pressed_n     = pressed;
    hold_active_n = hold_active;

    if (!enable) begin
      state_n       = IDLE;
      tmr_clear     = 1'b1;
      pressed_n     = 1'b0;
      hold_active_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tmr_clear = 1'b1;
          if (active && !prev_active) begin
            state_n   = PRESSED;
            press_n   = 1'b1;
            pressed_n = 1'b1;
          end
        end
        PRESSED, HELD: begin
          if (!active) begin
            state_n       = IDLE;
            tmr_clear     = 1'b1;
            release_n     = 1'b1;
            pressed_n     = 1'b0;
            hold_active_n = 1'b0;
          end else if (state == PRESSED) begin
            if (tmr_done) begin
              state_n       = HELD;
              tmr_clear     = 1'b1;
              hold_n        = 1'b1;
              hold_active_n = 1'b1;
            end else begin
              tmr_en = 1'b1;
            end
          end else if (REPEAT_ON) begin
            if (tmr_done) begin
              tmr_clear = 1'b1;
              repeat_n  = 1'b1;
            end else begin
              tmr_en = 1'b1;
            end
          end
        end
        default: begin
          state_n   = IDLE;
          tmr_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      prev_active   <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      pressed       <= 1'b0;
      hold_active   <= 1'b0;
    end else begin
      state         <= state_n;
      prev_active   <= active;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      hold_pulse    <= hold_n;
      repeat_pulse  <= repeat_n;
      pressed       <= pressed_n;
      hold_active   <= hold_active_n;
    end
  end

endmodule
